axi_master_unpacker: RTL and testbench
======================================

# axi_master_unpacker

Load-side DMA engine for the systolic array: on a start pulse it fetches a block of matrix rows from DDR over AXI4 read bursts and unpacks each burst into one full-width SRAM row write. It sits between the AXI interconnect and the input-buffer SRAM write port. It is the read-direction counterpart of `axi_master_packer`, and uses the same row layout and register conventions.

## Interface
- `AXI_DATA_WIDTH`, 64: AXI read data width in bits.
- `SRAM_DATA_WIDTH`, 32: width of one array element in bits.
- `ARRAY_WIDTH`, 16: number of elements per SRAM row.
- `ADDR_WIDTH`, 10: SRAM row address width.
- Derived values:
  - EPB = AXI_DATA_WIDTH/SRAM_DATA_WIDTH elements per beat; 2 by default.
  - BEATS = ARRAY_WIDTH/EPB beats per row; 8 by default.
  - ROW_BYTES = ARRAY_WIDTH*SRAM_DATA_WIDTH/8 bytes per row; 64 by default.
- Ports (clock and reset first):
  - `clk` in 1: single clock; all logic on posedge.
  - `rst` in 1: reset, synchronous, active-low.
  - `start_load` in 1: one-cycle start pulse; sampled only in IDLE.
  - `load_done_irq` out 1: one-cycle completion pulse.
  - `load_err` out 1: sticky error flag; cleared on an accepted start.
  - `reg_ddr_addr` in 64: DDR byte address of row 0; only bits [31:0] are used.
  - `reg_m_len` in 32: number of rows to load.
  - `reg_addr_s` in 32: first SRAM row; only bits [ADDR_WIDTH-1:0] are used.
  - `wr_en` out 1: SRAM row write strobe.
  - `wr_addr` out ADDR_WIDTH: SRAM row address.
  - `wr_data` out SRAM_DATA_WIDTH x [ARRAY_WIDTH]: unpacked row.
  - `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1: AXI read address channel.
  - `rdata` in AXI_DATA_WIDTH, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI read data channel.

## Operation
- States: IDLE, ADDR, DATA, WRITE, DONE.
- IDLE, when `start_load`=1:
  - Latch `reg_ddr_addr[31:0]`, `reg_m_len` and `reg_addr_s` into internal registers.
  - Clear `row_cnt` and `load_err`.
  - Go to DONE if the latched `m_len`==0; otherwise go to ADDR.
  - Register inputs are ignored outside IDLE, and `start_load` is ignored outside IDLE.
- ADDR:
  - Drive `arvalid`=1 with `araddr` = base + `row_cnt`*ROW_BYTES (mod 2^32).
  - `arlen` = BEATS-1 (7), `arsize` = log2(AXI_DATA_WIDTH/8) (3), `arburst` = 2'b01 (INCR).
  - `araddr` and `arlen` stay stable while `arvalid`=1 and `arready`=0.
  - On the `arvalid`&`arready` handshake, clear `beat_cnt` and go to DATA.
- DATA:
  - `rready`=1.
  - Each `rvalid`&`rready` beat k writes elements EPB*k .. EPB*k+EPB-1 of the row buffer; element EPB*k+j comes from `rdata[SRAM_DATA_WIDTH*j +: SRAM_DATA_WIDTH]` (lowest lane = lowest index).
  - Set `load_err` if `rresp`!=2'b00.
  - Set `load_err` if `rlast` does not equal (`beat_cnt`==BEATS-1).
  - The burst ends on the handshake where `beat_cnt`==BEATS-1, regardless of `rlast`; go to WRITE.
- WRITE:
  - One cycle with `wr_en`=1, `wr_addr` = (`addr_s` + `row_cnt`) mod 2^ADDR_WIDTH, and `wr_data` = row buffer.
  - Increment `row_cnt`.
  - Go to DONE if the incremented `row_cnt`==`m_len`; otherwise go to ADDR.
- DONE: `load_done_irq`=1 for exactly one cycle, then go to IDLE.
- Only one burst is outstanding at a time; AR is never issued while in DATA.
- Data from an errored burst is still written to SRAM; `load_err` only reports the error.

## Timing
- Reset (`rst`=0 at a posedge):
  - State goes to IDLE.
  - `arvalid`, `rready`, `wr_en`, `load_done_irq` and `load_err` are 0.
  - `araddr`, `arlen`, `wr_addr`, `wr_data` and the row buffer are 0.
  - `arsize`=3 and `arburst`=2'b01 are constants and hold these values out of reset.
  - Reset mid-transfer abandons the AXI transaction without an irq; the interconnect is reset together with this block.
- `start_load` sampled at edge T: `arvalid`=1 from T+1.
- AR handshake at edge A: `rready`=1 from A+1.
- Last R handshake at edge R: `wr_en`=1 during cycle R+1.
- Next row: `arvalid`=1 from R+2.
- Last row: `load_done_irq`=1 during R+2.
- All outputs are registered; there is no combinational path from AXI inputs to AXI outputs.
- `rvalid` is legal while `rready`=0; data is held by the slave and is not sampled.
- `m_len`==0: `load_done_irq` at T+1; no AXI or SRAM activity.
- `wr_addr` wraps from 2^ADDR_WIDTH-1 to 0.

## Test plan
- **Basic load:** `reg_ddr_addr`=0x1000_0000, `reg_m_len`=2, `reg_addr_s`=10; memory word at byte address a = {a[31:3], a[2]}.
  - Two AR transactions: 0x1000_0000 and 0x1000_0040, each with `arlen`=7, `arsize`=3, `arburst`=1.
  - SRAM writes to rows 10 and 11 with element i equal to the 32-bit word at (row base + 4i).
  - One `load_done_irq` pulse; `load_err`=0.
- **Backpressure:** `arready` delay random 0–3 cycles, `rvalid` gaps random 0–2 cycles.
  - Identical SRAM contents to the basic load.
  - `araddr` stable while stalled.
  - Exactly 16 R handshakes.
- **Zero length:** `reg_m_len`=0 → `load_done_irq` one cycle after start; no `arvalid` and no `wr_en`.
- **Errors:** `rresp`=2'b10 on beat 3 of row 0, and `rlast` asserted on beat 5 of row 1.
  - `load_err`=1 and stays 1.
  - Both rows are still written.
  - `load_err` clears on the next `start_load`.
- **Wrap and ignored start:** `reg_addr_s`=1023, `reg_m_len`=2.
  - Writes go to rows 1023 then 0.
  - A second `start_load` pulse during DATA has no effect (still exactly 2 AR transactions).
- **Reset mid-burst:** assert `rst`=0 during beat 4.
  - All outputs return to reset values the next cycle; no irq.
  - A new start after reset loads correctly.

Source files
------------

// File: rtl/axi_master_unpacker.sv
// Load-side DMA engine: fetches matrix rows from DDR with AXI4 INCR read bursts
// and writes each completed burst to the input-buffer SRAM as one full-width row.
module axi_master_unpacker #(
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int ARRAY_WIDTH     = 16,
    parameter int ADDR_WIDTH      = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_load,
    output logic                       load_done_irq,
    output logic                       load_err,
    input  logic [63:0]                reg_ddr_addr,
    input  logic [31:0]                reg_m_len,
    input  logic [31:0]                reg_addr_s,
    output logic                       wr_en,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [SRAM_DATA_WIDTH-1:0] wr_data [ARRAY_WIDTH],
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic                       arvalid,
    input  logic                       arready,
    input  logic [AXI_DATA_WIDTH-1:0]  rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready
);

    localparam int EPB       = AXI_DATA_WIDTH / SRAM_DATA_WIDTH;
    localparam int BEATS     = ARRAY_WIDTH / EPB;
    localparam int ROW_BYTES = ARRAY_WIDTH * SRAM_DATA_WIDTH / 8;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [7:0]        ARLEN     = 8'(BEATS - 1);
    localparam logic [2:0]        ARSIZE    = 3'($clog2(AXI_DATA_WIDTH / 8));

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [31:0]                r_m_len;
    logic [31:0]                r_row_cnt;
    logic [BEAT_W-1:0]          r_beat_cnt;
    logic [31:0]                r_araddr;
    logic [7:0]                 r_arlen;
    logic                       r_arvalid;
    logic                       r_rready;
    logic                       r_wr_en;
    logic [ADDR_WIDTH-1:0]      r_wr_addr;
    logic [SRAM_DATA_WIDTH-1:0] r_row [ARRAY_WIDTH];
    logic                       r_irq;
    logic                       r_err;

    logic        w_start;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_last_beat;
    logic [31:0] w_row_cnt_inc;
    logic        w_unused;

    assign w_start       = (r_state == S_IDLE) && start_load;
    assign w_ar_hs       = r_arvalid && arready;
    assign w_r_hs        = r_rready && rvalid;
    assign w_last_beat   = (r_beat_cnt == LAST_BEAT);
    assign w_row_cnt_inc = r_row_cnt + 32'd1;
    assign w_unused      = ^{reg_ddr_addr[63:32], reg_addr_s[31:ADDR_WIDTH]};

    always_comb begin
        // NOTE: default assigned first so every path writes w_state_next and no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start_load) w_state_next = (reg_m_len == 32'd0) ? S_DONE : S_ADDR;
            S_ADDR:  if (w_ar_hs) w_state_next = S_DATA;
            S_DATA:  if (w_r_hs && w_last_beat) w_state_next = S_WRITE;
            S_WRITE: w_state_next = (w_row_cnt_inc == r_m_len) ? S_DONE : S_ADDR;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_m_len    <= '0;
            r_row_cnt  <= '0;
            r_beat_cnt <= '0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_irq      <= 1'b0;
            r_err      <= 1'b0;
            // NOTE: the row buffer is reset because it drives wr_data directly.
            for (int i = 0; i < ARRAY_WIDTH; i++) r_row[i] <= '0;
        end else begin
            r_state   <= w_state_next;
            // Strobes are registered from the next state so no AXI input reaches an output combinationally.
            r_arvalid <= (w_state_next == S_ADDR);
            r_rready  <= (w_state_next == S_DATA);
            r_wr_en   <= (w_state_next == S_WRITE);
            r_irq     <= (w_state_next == S_DONE);

            if (w_start) begin
                r_araddr  <= reg_ddr_addr[31:0];
                r_arlen   <= ARLEN;
                r_m_len   <= reg_m_len;
                r_wr_addr <= reg_addr_s[ADDR_WIDTH-1:0];
                r_row_cnt <= '0;
                r_err     <= 1'b0;
            end

            if (w_ar_hs) r_beat_cnt <= '0;

            if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                if (rresp != 2'b00 || rlast != w_last_beat) r_err <= 1'b1;
                // Lowest lane of the beat lands in the lowest element index.
                for (int i = 0; i < ARRAY_WIDTH; i++) begin
                    if (i / EPB == int'(r_beat_cnt))
                        r_row[i] <= rdata[SRAM_DATA_WIDTH*(i%EPB) +: SRAM_DATA_WIDTH];
                end
            end

            // Running address registers stand in for base + row_cnt * stride.
            if (r_state == S_WRITE) begin
                r_row_cnt <= w_row_cnt_inc;
                r_araddr  <= r_araddr + 32'(ROW_BYTES);
                r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
            end
        end
    end

    assign araddr        = r_araddr;
    assign arlen         = r_arlen;
    assign arsize        = ARSIZE;
    assign arburst       = 2'b01;
    assign arvalid       = r_arvalid;
    assign rready        = r_rready;
    assign wr_en         = r_wr_en;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_row;
    assign load_done_irq = r_irq;
    assign load_err      = r_err;

endmodule

// File: tb/tb_axi_master_unpacker.sv
// Directed bench for axi_master_unpacker: AXI read slave backed by a synthetic
// memory (word at byte a = {a[31:3], a[2]}), SRAM write logger, assertion checks.
module tb_axi_master_unpacker;

    localparam int AXI_DATA_WIDTH  = 64;
    localparam int SRAM_DATA_WIDTH = 32;
    localparam int ARRAY_WIDTH     = 16;
    localparam int ADDR_WIDTH      = 10;
    localparam int BEATS           = 8;
    localparam int LOG_N           = 32;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start_load;
    logic                       load_done_irq;
    logic                       load_err;
    logic [63:0]                reg_ddr_addr;
    logic [31:0]                reg_m_len;
    logic [31:0]                reg_addr_s;
    logic                       wr_en;
    logic [ADDR_WIDTH-1:0]      wr_addr;
    logic [SRAM_DATA_WIDTH-1:0] wr_data [ARRAY_WIDTH];
    logic [31:0]                araddr;
    logic [7:0]                 arlen;
    logic [2:0]                 arsize;
    logic [1:0]                 arburst;
    logic                       arvalid;
    logic                       arready;
    logic [AXI_DATA_WIDTH-1:0]  rdata;
    logic [1:0]                 rresp;
    logic                       rlast;
    logic                       rvalid;
    logic                       rready;

    axi_master_unpacker #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .SRAM_DATA_WIDTH(SRAM_DATA_WIDTH),
        .ARRAY_WIDTH    (ARRAY_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_load   (start_load),
        .load_done_irq(load_done_irq),
        .load_err     (load_err),
        .reg_ddr_addr (reg_ddr_addr),
        .reg_m_len    (reg_m_len),
        .reg_addr_s   (reg_addr_s),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .araddr       (araddr),
        .arlen        (arlen),
        .arsize       (arsize),
        .arburst      (arburst),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave configuration, written only by the stimulus block.
    int ar_delay_max   = 0;
    int r_gap_max      = 0;
    int resp_err_ar    = -1;
    int resp_err_beat  = -1;
    int rlast_err_ar   = -1;
    int rlast_err_beat = -1;

    // Slave/monitor counters and logs, written only by the slave block.
    int                         ar_cnt;
    int                         r_cnt;
    int                         wr_cnt;
    int                         irq_cnt;
    int                         ar_unstable;
    int                         ar_attr_bad;
    logic [31:0]                ar_log      [LOG_N];
    logic [ADDR_WIDTH-1:0]      wr_addr_log [LOG_N];
    logic [SRAM_DATA_WIDTH-1:0] wr_data_log [LOG_N][ARRAY_WIDTH];
    int                         wr_lag_log  [LOG_N];

    // Snapshots taken by the stimulus block before each scenario.
    int s_ar, s_r, s_wr, s_irq, s_un, s_bad;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:3], a[2]};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_ar  = ar_cnt;
        s_r   = r_cnt;
        s_wr  = wr_cnt;
        s_irq = irq_cnt;
        s_un  = ar_unstable;
        s_bad = ar_attr_bad;
    endtask

    task automatic start(input logic [31:0] ddr, input logic [31:0] len, input logic [31:0] s);
        reg_ddr_addr = {32'hDEAD_BEEF, ddr};
        reg_m_len    = len;
        reg_addr_s   = s;
        start_load   = 1'b1;
        step();
        start_load   = 1'b0;
        reg_ddr_addr = '1;
        reg_m_len    = 32'd77;
        reg_addr_s   = 32'h155;
    endtask

    task automatic wait_irq(input string tag, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            if (load_done_irq === 1'b1) seen = 1'b1;
            else step();
        end
        check_eq(tag, 64'(seen), 64'd1);
        if (seen) begin
            step();
            check_eq({tag, "_one_cycle"}, 64'(load_done_irq), 64'd0);
        end
        repeat (3) step();
    endtask

    task automatic check_row(input string tag, input int idx, input logic [ADDR_WIDTH-1:0] exp_addr,
                             input logic [31:0] base);
        int bad = 0;
        int k;
        k = (idx >= 0 && idx < LOG_N) ? idx : 0;
        check_eq({tag, "_addr"}, 64'(wr_addr_log[k]), 64'(exp_addr));
        for (int i = 0; i < ARRAY_WIDTH; i++)
            if (wr_data_log[k][i] !== mem_word(base + 32'(4 * i))) bad++;
        check_eq({tag, "_bad_elems"}, 64'(bad), 64'd0);
        check_eq({tag, "_wr_lag"}, 64'(wr_lag_log[k]), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        int nz = 0;
        for (int i = 0; i < ARRAY_WIDTH; i++) if (wr_data[i] !== '0) nz++;
        check_eq({tag, "_arvalid"}, 64'(arvalid), 64'd0);
        check_eq({tag, "_rready"}, 64'(rready), 64'd0);
        check_eq({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check_eq({tag, "_irq"}, 64'(load_done_irq), 64'd0);
        check_eq({tag, "_err"}, 64'(load_err), 64'd0);
        check_eq({tag, "_araddr"}, 64'(araddr), 64'd0);
        check_eq({tag, "_arlen"}, 64'(arlen), 64'd0);
        check_eq({tag, "_arsize"}, 64'(arsize), 64'd3);
        check_eq({tag, "_arburst"}, 64'(arburst), 64'd1);
        check_eq({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check_eq({tag, "_wr_data_nonzero"}, 64'(nz), 64'd0);
    endtask

    // AXI read slave plus SRAM/irq monitor; acts 2 time units after each falling edge.
    initial begin : axi_slave
        int          ar_wait, r_gap, beat, cur_ar, cyc, last_r_cyc;
        logic        in_burst, ar_pend;
        logic [31:0] burst_addr, ar_hold, a;
        logic        p_rst, p_arv, p_arr, p_rv, p_rr;
        logic [31:0] p_araddr;
        logic [7:0]  p_arlen;
        logic [2:0]  p_arsize;
        logic [1:0]  p_arburst;
        ar_cnt = 0; r_cnt = 0; wr_cnt = 0; irq_cnt = 0; ar_unstable = 0; ar_attr_bad = 0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
        ar_wait = 0; r_gap = 0; beat = 0; cur_ar = 0; cyc = 0; last_r_cyc = -100;
        in_burst = 1'b0; ar_pend = 1'b0; burst_addr = '0; ar_hold = '0; a = '0;
        p_rst = 1'b0; p_arv = 1'b0; p_arr = 1'b0; p_rv = 1'b0; p_rr = 1'b0;
        p_araddr = '0; p_arlen = '0; p_arsize = '0; p_arburst = '0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            // Handshakes that completed at the preceding rising edge.
            if (p_rst) begin
                if (p_arv && p_arr) begin
                    if (ar_cnt < LOG_N) ar_log[ar_cnt] = p_araddr;
                    if (p_arlen !== 8'd7 || p_arsize !== 3'd3 || p_arburst !== 2'b01) ar_attr_bad++;
                    cur_ar = ar_cnt;
                    ar_cnt++;
                    burst_addr = p_araddr;
                    in_burst = 1'b1;
                    beat = 0;
                    arready = 1'b0;
                    ar_pend = 1'b0;
                    r_gap = $urandom_range(r_gap_max, 0);
                end
                if (p_rv && p_rr) begin
                    r_cnt++;
                    last_r_cyc = cyc;
                    rvalid = 1'b0;
                    rlast = 1'b0;
                    rresp = 2'b00;
                    beat++;
                    if (beat == BEATS) in_burst = 1'b0;
                    r_gap = $urandom_range(r_gap_max, 0);
                end
            end
            if (wr_en === 1'b1) begin
                if (wr_cnt < LOG_N) begin
                    wr_addr_log[wr_cnt] = wr_addr;
                    for (int i = 0; i < ARRAY_WIDTH; i++) wr_data_log[wr_cnt][i] = wr_data[i];
                    wr_lag_log[wr_cnt] = cyc - last_r_cyc;
                end
                wr_cnt++;
            end
            if (load_done_irq === 1'b1) irq_cnt++;
            if (!rst || !p_rst) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                in_burst = 1'b0; ar_pend = 1'b0;
            end else begin
                if (arvalid === 1'b1 && !in_burst) begin
                    if (ar_pend) begin
                        if (araddr !== ar_hold) ar_unstable++;
                    end else begin
                        ar_pend = 1'b1;
                        ar_hold = araddr;
                        ar_wait = $urandom_range(ar_delay_max, 0);
                    end
                    if (!arready) begin
                        if (ar_wait == 0) arready = 1'b1;
                        else ar_wait--;
                    end
                end
                if (in_burst && !rvalid) begin
                    if (r_gap == 0) begin
                        a = burst_addr + 32'(8 * beat);
                        rdata = {mem_word(a + 32'd4), mem_word(a)};
                        rresp = (cur_ar == resp_err_ar && beat == resp_err_beat) ? 2'b10 : 2'b00;
                        rlast = (cur_ar == rlast_err_ar) ? (beat == rlast_err_beat) : (beat == BEATS - 1);
                        rvalid = 1'b1;
                    end else begin
                        r_gap--;
                    end
                end
            end
            p_rst = rst; p_arv = arvalid; p_arr = arready; p_rv = rvalid; p_rr = rready;
            p_araddr = araddr; p_arlen = arlen; p_arsize = arsize; p_arburst = arburst;
        end
    end

    initial begin : stim
        bit found;
        rst          = 1'b0;
        start_load   = 1'b0;
        reg_ddr_addr = '0;
        reg_m_len    = '0;
        reg_addr_s   = '0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (2) step();

        // Basic two-row load.
        snap();
        start(32'h1000_0000, 32'd2, 32'd10);
        check_eq("basic_arvalid_T1", 64'(arvalid), 64'd1);
        check_eq("basic_araddr_T1", 64'(araddr), 64'h1000_0000);
        check_eq("basic_arlen_T1", 64'(arlen), 64'd7);
        wait_irq("basic_irq", 200);
        check_eq("basic_ar_count", 64'(ar_cnt - s_ar), 64'd2);
        check_eq("basic_ar0", 64'(ar_log[s_ar]), 64'h1000_0000);
        check_eq("basic_ar1", 64'(ar_log[s_ar+1]), 64'h1000_0040);
        check_eq("basic_ar_attr", 64'(ar_attr_bad - s_bad), 64'd0);
        check_eq("basic_r_count", 64'(r_cnt - s_r), 64'd16);
        check_eq("basic_wr_count", 64'(wr_cnt - s_wr), 64'd2);
        check_row("basic_row0", s_wr, 10'd10, 32'h1000_0000);
        check_row("basic_row1", s_wr + 1, 10'd11, 32'h1000_0040);
        check_eq("basic_irq_count", 64'(irq_cnt - s_irq), 64'd1);
        check_eq("basic_err", 64'(load_err), 64'd0);

        // Same load under AR and R backpressure.
        snap();
        ar_delay_max = 3;
        r_gap_max    = 2;
        start(32'h1000_0000, 32'd2, 32'd10);
        wait_irq("bp_irq", 400);
        check_eq("bp_ar_count", 64'(ar_cnt - s_ar), 64'd2);
        check_eq("bp_ar_unstable", 64'(ar_unstable - s_un), 64'd0);
        check_eq("bp_r_count", 64'(r_cnt - s_r), 64'd16);
        check_eq("bp_wr_count", 64'(wr_cnt - s_wr), 64'd2);
        check_row("bp_row0", s_wr, 10'd10, 32'h1000_0000);
        check_row("bp_row1", s_wr + 1, 10'd11, 32'h1000_0040);
        check_eq("bp_err", 64'(load_err), 64'd0);
        ar_delay_max = 0;
        r_gap_max    = 0;

        // Zero-length load.
        snap();
        start(32'h7000_0000, 32'd0, 32'd5);
        check_eq("zero_irq_T1", 64'(load_done_irq), 64'd1);
        check_eq("zero_arvalid_T1", 64'(arvalid), 64'd0);
        step();
        check_eq("zero_irq_one_cycle", 64'(load_done_irq), 64'd0);
        repeat (5) step();
        check_eq("zero_ar_count", 64'(ar_cnt - s_ar), 64'd0);
        check_eq("zero_wr_count", 64'(wr_cnt - s_wr), 64'd0);
        check_eq("zero_irq_count", 64'(irq_cnt - s_irq), 64'd1);

        // Bad rresp on row 0 beat 3, early rlast on row 1 beat 5.
        snap();
        resp_err_ar    = s_ar;
        resp_err_beat  = 3;
        rlast_err_ar   = s_ar + 1;
        rlast_err_beat = 5;
        start(32'h2000_0000, 32'd2, 32'd20);
        wait_irq("err_irq", 200);
        check_eq("err_flag", 64'(load_err), 64'd1);
        check_eq("err_wr_count", 64'(wr_cnt - s_wr), 64'd2);
        check_row("err_row0", s_wr, 10'd20, 32'h2000_0000);
        check_row("err_row1", s_wr + 1, 10'd21, 32'h2000_0040);
        repeat (5) step();
        check_eq("err_sticky", 64'(load_err), 64'd1);
        resp_err_ar  = -1;
        rlast_err_ar = -1;
        start(32'h7000_0000, 32'd0, 32'd0);
        check_eq("err_cleared_by_start", 64'(load_err), 64'd0);
        repeat (3) step();

        // SRAM address wrap with an ignored start pulse during DATA.
        snap();
        start(32'h0000_3000, 32'd2, 32'd1023);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (rready === 1'b1) found = 1'b1;
            else step();
        end
        check_eq("wrap_reached_data", 64'(found), 64'd1);
        reg_ddr_addr = 64'h9000_0000;
        reg_m_len    = 32'd5;
        reg_addr_s   = 32'd7;
        start_load   = 1'b1;
        step();
        start_load   = 1'b0;
        wait_irq("wrap_irq", 200);
        check_eq("wrap_ar_count", 64'(ar_cnt - s_ar), 64'd2);
        check_eq("wrap_ar0", 64'(ar_log[s_ar]), 64'h0000_3000);
        check_eq("wrap_ar1", 64'(ar_log[s_ar+1]), 64'h0000_3040);
        check_eq("wrap_wr_count", 64'(wr_cnt - s_wr), 64'd2);
        check_row("wrap_row0", s_wr, 10'd1023, 32'h0000_3000);
        check_row("wrap_row1", s_wr + 1, 10'd0, 32'h0000_3040);
        check_eq("wrap_irq_count", 64'(irq_cnt - s_irq), 64'd1);

        // Reset in the middle of a burst, with an error already flagged.
        snap();
        resp_err_ar   = s_ar;
        resp_err_beat = 0;
        start(32'h4000_0000, 32'd2, 32'd50);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            if (r_cnt - s_r >= 4) found = 1'b1;
            else step();
        end
        check_eq("rstmid_reached_beat4", 64'(found), 64'd1);
        check_eq("rstmid_err_before", 64'(load_err), 64'd1);
        rst = 1'b0;
        step();
        check_reset_outputs("rstmid");
        rst = 1'b1;
        resp_err_ar = -1;
        repeat (10) step();
        check_eq("rstmid_no_irq", 64'(irq_cnt - s_irq), 64'd0);
        check_eq("rstmid_no_wr", 64'(wr_cnt - s_wr), 64'd0);

        // Fresh single-row load after reset.
        snap();
        start(32'h5000_0000, 32'd1, 32'd60);
        wait_irq("post_rst_irq", 200);
        check_eq("post_rst_ar_count", 64'(ar_cnt - s_ar), 64'd1);
        check_eq("post_rst_ar0", 64'(ar_log[s_ar]), 64'h5000_0000);
        check_eq("post_rst_wr_count", 64'(wr_cnt - s_wr), 64'd1);
        check_row("post_rst_row0", s_wr, 10'd60, 32'h5000_0000);
        check_eq("post_rst_err", 64'(load_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
